// File: rtl/mem_stage_iw.sv
// rtl/mem_stage_iw.sv - memory stage with wait-stated data memory and IM/IW register
module mem_stage_iw #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] RD2M,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  rdM,
  input  logic [31:0] PCPlus4M,
  output logic        StallM,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  rdW,
  output logic [31:0] PCPlus4W
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam int         WS_M1    = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [2:0] CNT_LOAD = 3'(WS_M1);
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  cnt;
  logic [2:0]  cnt_next;
  logic        acc;
  logic        stall;
  logic        complete;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];

  // Byte offset and bits above the array depth do not select a word; addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ALUResultM[31:AW+2], ALUResultM[1:0]};

  assign idx = ALUResultM[AW+1:2];

  // State register for the wait-state sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: an access stalls for WAIT_STATES cycles, then completes.
  always_comb begin
    acc        = MemWriteM | (ResultSrcM == 2'b01);
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc && HAS_WAIT) begin
          stall      = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != 3'd0) begin
          stall    = 1'b1;
          cnt_next = cnt - 3'd1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign complete = ~stall;
  // Reset must drop the stall at once, even while the held access is still presented.
  assign StallM   = stall & ~reset;

  // Data memory write; only on a completing edge, and never while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && complete && MemWriteM) begin
      mem[idx] <= RD2M;
    end
  end

  // IM/IW pipeline register: bubble while stalled, instruction fields when completing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      rdW        <= 5'd0;
      PCPlus4W   <= 32'd0;
    end else if (stall) begin
      ALUResultW <= 32'd0;
      ReadDataW  <= 32'd0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      rdW        <= 5'd0;
      PCPlus4W   <= 32'd0;
    end else begin
      ALUResultW <= ALUResultM;
      ReadDataW  <= mem[idx];
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      rdW        <= rdM;
      PCPlus4W   <= PCPlus4M;
    end
  end

endmodule

// File: tb/tb_mem_stage_iw.sv
// tb/tb_mem_stage_iw.sv - self-checking bench for mem_stage_iw at three wait-state settings
module tb_mem_stage_iw;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] alu_m [3];
  logic [31:0] rd2_m [3];
  logic [31:0] pc_m  [3];
  logic        regw_m[3];
  logic        memw_m[3];
  logic [1:0]  rsrc_m[3];
  logic [4:0]  rd_m  [3];
  logic        stall_m[3];
  logic [31:0] alu_w [3];
  logic [31:0] rdata_w[3];
  logic [31:0] pc_w  [3];
  logic        regw_w[3];
  logic [1:0]  rsrc_w[3];
  logic [4:0]  rd_w  [3];

  int checks = 0;
  int failures = 0;

  bit [31:0] ref_mem  [3][4096];
  bit        ref_known[3][4096];

  mem_stage_iw #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .ALUResultM(alu_m[0]), .RD2M(rd2_m[0]), .RegWriteM(regw_m[0]),
    .MemWriteM(memw_m[0]), .ResultSrcM(rsrc_m[0]), .rdM(rd_m[0]), .PCPlus4M(pc_m[0]),
    .StallM(stall_m[0]), .ALUResultW(alu_w[0]), .ReadDataW(rdata_w[0]), .RegWriteW(regw_w[0]),
    .ResultSrcW(rsrc_w[0]), .rdW(rd_w[0]), .PCPlus4W(pc_w[0]));

  mem_stage_iw #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .ALUResultM(alu_m[1]), .RD2M(rd2_m[1]), .RegWriteM(regw_m[1]),
    .MemWriteM(memw_m[1]), .ResultSrcM(rsrc_m[1]), .rdM(rd_m[1]), .PCPlus4M(pc_m[1]),
    .StallM(stall_m[1]), .ALUResultW(alu_w[1]), .ReadDataW(rdata_w[1]), .RegWriteW(regw_w[1]),
    .ResultSrcW(rsrc_w[1]), .rdW(rd_w[1]), .PCPlus4W(pc_w[1]));

  mem_stage_iw #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .ALUResultM(alu_m[2]), .RD2M(rd2_m[2]), .RegWriteM(regw_m[2]),
    .MemWriteM(memw_m[2]), .ResultSrcM(rsrc_m[2]), .rdM(rd_m[2]), .PCPlus4M(pc_m[2]),
    .StallM(stall_m[2]), .ALUResultW(alu_w[2]), .ReadDataW(rdata_w[2]), .RegWriteW(regw_w[2]),
    .ResultSrcW(rsrc_w[2]), .rdW(rd_w[2]), .PCPlus4W(pc_w[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 2) ? 64 : 256;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Non-access instruction with nonzero fields, so W outputs stay visibly nonzero.
  task automatic set_idle(input int d);
    alu_m[d]  = 32'h55 + 32'(d);
    rd2_m[d]  = 32'd0;
    regw_m[d] = 1'b1;
    memw_m[d] = 1'b0;
    rsrc_m[d] = 2'b00;
    rd_m[d]   = 5'd3;
    pc_m[d]   = 32'd4;
  endtask

  task automatic check_zero_w(input int d, input string tag);
    check({tag, "_alu"}, alu_w[d], 32'd0);
    check({tag, "_rdata"}, rdata_w[d], 32'd0);
    check({tag, "_pc"}, pc_w[d], 32'd0);
    check({tag, "_fields"}, {24'd0, regw_w[d], rsrc_w[d], rd_w[d]}, 32'd0);
  endtask

  // Present one instruction right after an edge and follow it to its completing edge.
  task automatic issue(input int d, input logic [31:0] alu, input logic [31:0] rd2,
                       input logic regw, input logic memw, input logic [1:0] rsrc,
                       input logic [4:0] rd, input logic [31:0] pc, output logic [31:0] rdata);
    int  idx;
    int  nstall;
    int  exp_stall;
    bit  acc;
    bit  s;
    bit  done;
    alu_m[d]  = alu;
    rd2_m[d]  = rd2;
    regw_m[d] = regw;
    memw_m[d] = memw;
    rsrc_m[d] = rsrc;
    rd_m[d]   = rd;
    pc_m[d]   = pc;
    acc       = memw || (rsrc == 2'b01);
    exp_stall = acc ? ws_of(d) : 0;
    idx       = int'(alu[31:2]) % depth_of(d);
    nstall    = 0;
    done      = 1'b0;
    rdata     = 32'd0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      s = stall_m[d];
      @(posedge clk);
      #1;
      if (s) begin
        nstall++;
        check($sformatf("bubble_d%0d", d),
              {24'd0, regw_w[d], rsrc_w[d], rd_w[d]} | {31'd0, |{alu_w[d], rdata_w[d], pc_w[d]}},
              32'd0);
      end else begin
        done = 1'b1;
        check($sformatf("alu_d%0d", d), alu_w[d], alu);
        check($sformatf("fields_d%0d", d), {24'd0, regw_w[d], rsrc_w[d], rd_w[d]},
              {24'd0, regw, rsrc, rd});
        check($sformatf("pc_d%0d", d), pc_w[d], pc);
        if (ref_known[d][idx]) check($sformatf("rdata_d%0d", d), rdata_w[d], ref_mem[d][idx]);
        rdata = rdata_w[d];
        if (memw) begin
          ref_mem[d][idx]   = rd2;
          ref_known[d][idx] = 1'b1;
        end
      end
    end
    if (!done) check($sformatf("timeout_d%0d", d), 32'd0, 32'd1);
    check($sformatf("stalls_d%0d", d), 32'(nstall), 32'(exp_stall));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [3:0]  w;
    int          kind;

    reset = 1'b1;
    for (int d = 0; d < 3; d++) set_idle(d);
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_stall_d%0d", d), {31'd0, stall_m[d]}, 32'd0);
      check_zero_w(d, $sformatf("rst_d%0d", d));
    end
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Zero wait states: store then load the same word on consecutive instructions.
    issue(0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b00, 5'd0, 32'h100, r);
    issue(0, 32'h10, 32'h0, 1'b1, 1'b0, 2'b01, 5'd9, 32'h104, r);
    check("ws0_store_load", r, 32'hDEADBEEF);
    set_idle(0);

    // Two wait states: address wrap and ignored byte offset.
    issue(1, 32'h404, 32'h1, 1'b0, 1'b1, 2'b00, 5'd0, 32'h200, r);
    issue(1, 32'h004, 32'h0, 1'b1, 1'b0, 2'b01, 5'd7, 32'h204, r);
    check("ws2_wrap_load", r, 32'h1);
    issue(1, 32'h007, 32'h0, 1'b1, 1'b0, 2'b01, 5'd8, 32'h208, r);
    check("ws2_lowbits_load", r, 32'h1);
    set_idle(1);

    // Three wait states: store followed by a single-cycle ALU op.
    issue(2, 32'h20, 32'h77, 1'b0, 1'b1, 2'b00, 5'd0, 32'h300, r);
    issue(2, 32'h7, 32'h0, 1'b1, 1'b0, 2'b00, 5'd5, 32'h304, r);

    // Reset in the second stall cycle of a store abandons it.
    issue(2, 32'h8, 32'h12345678, 1'b0, 1'b1, 2'b00, 5'd0, 32'h400, r);
    alu_m[2]  = 32'h8;
    rd2_m[2]  = 32'hAAAA5555;
    regw_m[2] = 1'b0;
    memw_m[2] = 1'b1;
    rsrc_m[2] = 2'b00;
    rd_m[2]   = 5'd0;
    pc_m[2]   = 32'h404;
    @(posedge clk);
    #1;
    check("pre_rst_stall_d2", {31'd0, stall_m[2]}, 32'd1);
    check("pre_rst_alu_d0", alu_w[0], 32'h55);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("mid_rst_stall_d%0d", d), {31'd0, stall_m[d]}, 32'd0);
      check_zero_w(d, $sformatf("mid_rst_d%0d", d));
    end
    set_idle(2);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    issue(2, 32'h8, 32'h0, 1'b1, 1'b0, 2'b01, 5'd4, 32'h408, r);
    check("ws3_abandoned_store", r, 32'h12345678);
    set_idle(2);

    // Randomized instruction streams checked against the reference model.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 80; n++) begin
        w = 4'($urandom_range(0, 15));
        a = ($urandom & 32'hFFFFC003) | {26'd0, w, 2'b00};
        kind = int'($urandom_range(0, 4));
        case (kind)
          0: issue(d, a, $urandom, 1'($urandom), 1'b1, 2'b00, 5'($urandom), $urandom, r);
          1: issue(d, a, $urandom, 1'($urandom), 1'b0, 2'b01, 5'($urandom), $urandom, r);
          2: issue(d, $urandom, $urandom, 1'($urandom), 1'b0, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00,
                   5'($urandom), $urandom, r);
          3: issue(d, $urandom, $urandom, 1'($urandom), 1'b0, 2'b10, 5'($urandom), $urandom, r);
          default: issue(d, a, $urandom, 1'($urandom), 1'b1, 2'b01, 5'($urandom), $urandom, r);
        endcase
      end
      set_idle(d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
